// File: rtl/desired_drive_pkg.sv
`default_nettype none
// ============================================================================
// Module      : desired_drive_pkg
// Description : Shared types and constants for the desired-drive target
//               current sequencer: FSM state encoding, torque offset default,
//               factor offsets, shared-multiplier widths and result slicing.
// Revision    : 1.0 - initial release
// ============================================================================
package desired_drive_pkg;

    // Sequencer states; the encoding is fixed so state values are stable in
    // waveforms and across tools.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL1 = 2'd1,
        ST_MUL2 = 2'd2,
        ST_MUL3 = 2'd3
    } drive_state_e;

    // Torque at or below this offset produces no assist.
    localparam logic [11:0] c_torque_min_default = 12'h380;

    // Offsets applied to the conditioned incline and cadence factors.
    localparam logic [8:0]  c_incline_offset     = 9'd256;
    localparam logic [5:0]  c_cadence_offset     = 6'd32;

    // Shared multiplier geometry.
    localparam int          c_mul_a_w            = 27;
    localparam int          c_mul_b_w            = 9;
    localparam int          c_prod_w             = 29;

    // Final product slicing: any of the top bits set saturates the result.
    localparam int          c_sat_msb            = 28;
    localparam int          c_sat_lsb            = 26;
    localparam int          c_res_msb            = 25;
    localparam int          c_res_lsb            = 14;

endpackage
`default_nettype wire

// File: rtl/drive_factors.sv
`default_nettype none
// ============================================================================
// Module      : drive_factors
// Description : Combinational conditioning of the raw sensor values into the
//               three multiplier factors.
//   avg_torque     in  12  unsigned averaged torque
//   cadence_vec    in   5  unsigned cadence
//   incline        in  13  signed incline
//   torque_pos     out 12  torque above TORQUE_MIN, else 0
//   cadence_factor out  6  cadence + 32 when cadence > 1, else 0
//   incline_lim    out  9  saturated incline + 256, clipped to 0..511
// Revision    : 1.0 - initial release
// ============================================================================
module drive_factors
    import desired_drive_pkg::*;
#(
    parameter logic [11:0] TORQUE_MIN = c_torque_min_default
) (
    input  logic [11:0] avg_torque,
    input  logic [4:0]  cadence_vec,
    input  logic [12:0] incline,
    output logic [11:0] torque_pos,
    output logic [5:0]  cadence_factor,
    output logic [8:0]  incline_lim
);

    logic [9:0]  w_inc_sat;
    logic [10:0] w_inc_sum;
    logic        w_inc_in_range;

    // The 13-bit value fits in 10-bit signed exactly when its top four bits
    // are all copies of the sign bit.
    assign w_inc_in_range = (incline[12:9] == 4'b0000) || (incline[12:9] == 4'b1111);
    assign w_inc_sat      = w_inc_in_range ? incline[9:0]
                          : (incline[12] ? 10'h200 : 10'h1FF);

    // 11-bit two's complement sum covers -256..767 without overflow.
    assign w_inc_sum = {w_inc_sat[9], w_inc_sat} + {2'b00, c_incline_offset};

    always_comb begin
        incline_lim = w_inc_sum[8:0];
        if (w_inc_sum[10]) begin
            incline_lim = 9'd0;
        end else if (w_inc_sum[9]) begin
            incline_lim = 9'h1FF;
        end
    end

    assign cadence_factor = (cadence_vec > 5'd1) ? ({1'b0, cadence_vec} + c_cadence_offset) : 6'd0;
    assign torque_pos     = (avg_torque > TORQUE_MIN) ? (avg_torque - TORQUE_MIN) : 12'd0;

endmodule
`default_nettype wire

// File: rtl/desired_drive_seq.sv
`default_nettype none
// ============================================================================
// Module      : desired_drive_seq
// Description : Sequenced computation of the motor target current using one
//               shared 27x9 multiplier over three steps:
//               torque_pos*incline_lim, *cadence_factor, *setting.
//   clk         in   1  system clock
//   rst_n       in   1  asynchronous active-low reset
//   start       in   1  request a computation (honoured only when idle)
//   avg_torque  in  12  unsigned averaged torque
//   cadence_vec in   5  unsigned cadence
//   incline     in  13  signed incline
//   setting     in   2  assist level 0..3
//   busy        out  1  computation in progress
//   valid       out  1  single-cycle pulse when target_curr updates
//   target_curr out 12  registered target current, held between updates
// Revision    : 1.0 - initial release
// ============================================================================
module desired_drive_seq
    import desired_drive_pkg::*;
#(
    parameter logic [11:0] TORQUE_MIN = c_torque_min_default
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] avg_torque,
    input  logic [4:0]  cadence_vec,
    input  logic [12:0] incline,
    input  logic [1:0]  setting,
    output logic        busy,
    output logic        valid,
    output logic [11:0] target_curr
);

    drive_state_e            r_state;
    drive_state_e            w_state_nxt;

    logic [11:0]             w_torque_pos;
    logic [5:0]              w_cadence_factor;
    logic [8:0]              w_incline_lim;

    logic [11:0]             r_torque_pos;
    logic [5:0]              r_cadence_factor;
    logic [8:0]              r_incline_lim;
    logic [1:0]              r_setting;
    logic [c_mul_a_w-1:0]    r_prod;
    logic                    r_valid;
    logic [11:0]             r_target;

    logic                    w_accept;
    logic                    w_load_prod;
    logic                    w_load_result;
    logic [c_mul_a_w-1:0]    w_mul_a;
    logic [c_mul_b_w-1:0]    w_mul_b;
    logic [c_prod_w-1:0]     w_prod;
    logic [11:0]             w_result;

    drive_factors #(
        .TORQUE_MIN     (TORQUE_MIN)
    ) u_factors (
        .avg_torque     (avg_torque),
        .cadence_vec    (cadence_vec),
        .incline        (incline),
        .torque_pos     (w_torque_pos),
        .cadence_factor (w_cadence_factor),
        .incline_lim    (w_incline_lim)
    );

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_load_prod   = 1'b0;
        w_load_result = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_MUL1;
                end
            end
            ST_MUL1: begin
                w_load_prod = 1'b1;
                w_state_nxt = ST_MUL2;
            end
            ST_MUL2: begin
                w_load_prod = 1'b1;
                w_state_nxt = ST_MUL3;
            end
            ST_MUL3: begin
                w_load_result = 1'b1;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand mux and the single shared multiplier
    // ------------------------------------------------------------------------
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            ST_MUL1: begin
                w_mul_a = {15'd0, r_torque_pos};
                w_mul_b = r_incline_lim;
            end
            ST_MUL2: begin
                w_mul_a = r_prod;
                w_mul_b = {3'd0, r_cadence_factor};
            end
            ST_MUL3: begin
                w_mul_a = r_prod;
                w_mul_b = {7'd0, r_setting};
            end
            default: begin
                w_mul_a = '0;
                w_mul_b = '0;
            end
        endcase
    end

    // Both operands are widened to the product width first so the multiply
    // itself is evaluated at 29 bits rather than at the wider operand width.
    assign w_prod   = {2'b00, w_mul_a} * {20'd0, w_mul_b};

    assign w_result = (|w_prod[c_sat_msb:c_sat_lsb]) ? 12'hFFF : w_prod[c_res_msb:c_res_lsb];

    // ------------------------------------------------------------------------
    // Operand latches, intermediate product and result register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_torque_pos     <= '0;
            r_cadence_factor <= '0;
            r_incline_lim    <= '0;
            r_setting        <= '0;
            r_prod           <= '0;
            r_valid          <= 1'b0;
            r_target         <= '0;
        end else begin
            if (w_accept) begin
                r_torque_pos     <= w_torque_pos;
                r_cadence_factor <= w_cadence_factor;
                r_incline_lim    <= w_incline_lim;
                r_setting        <= setting;
            end
            // p1 and p2 never exceed 27 bits, so the top product bits are
            // only meaningful in the final step.
            if (w_load_prod) begin
                r_prod <= w_prod[c_mul_a_w-1:0];
            end
            r_valid <= w_load_result;
            if (w_load_result) begin
                r_target <= w_result;
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign valid       = r_valid;
    assign target_curr = r_target;

endmodule
`default_nettype wire

// File: tb/tb_desired_drive_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_desired_drive_seq
// Description : Directed self-checking bench for desired_drive_seq with
//               hand-computed expected target currents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_desired_drive_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] avg_torque;
    logic [4:0]  cadence_vec;
    logic [12:0] incline;
    logic [1:0]  setting;
    logic        busy;
    logic        valid;
    logic [11:0] target_curr;

    int n_checks = 0;
    int n_fail   = 0;

    desired_drive_seq u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .avg_torque  (avg_torque),
        .cadence_vec (cadence_vec),
        .incline     (incline),
        .setting     (setting),
        .busy        (busy),
        .valid       (valid),
        .target_curr (target_curr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [11:0] a, input logic [4:0] c,
                          input logic [12:0] i, input logic [1:0] s);
        avg_torque  = a;
        cadence_vec = c;
        incline     = i;
        setting     = s;
    endtask

    // Called just after a falling edge: one start pulse, then latency and
    // result checks at each edge N..N+4.
    task automatic run(input string tag, input logic [11:0] a, input logic [4:0] c,
                       input logic [12:0] i, input logic [1:0] s, input logic [11:0] exp);
        set_in(a, c, i, s);
        start = 1'b1;
        tick();                                   // edge N
        start = 1'b0;
        check({tag, " busy@N"}, {11'd0, busy}, 12'd1);
        tick();                                   // N+1
        tick();                                   // N+2
        check({tag, " valid@N+2"}, {11'd0, valid}, 12'd0);
        tick();                                   // N+3
        check({tag, " valid@N+3"}, {11'd0, valid}, 12'd1);
        check({tag, " busy@N+3"},  {11'd0, busy},  12'd0);
        check({tag, " target"},    target_curr,    exp);
        tick();                                   // N+4
        check({tag, " valid@N+4"}, {11'd0, valid}, 12'd0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        set_in(12'h000, 5'h00, 13'h0000, 2'd0);
        repeat (2) @(negedge clk);
        check("reset busy",   {11'd0, busy},  12'd0);
        check("reset valid",  {11'd0, valid}, 12'd0);
        check("reset target", target_curr,    12'h000);
        rst_n = 1'b1;
        @(negedge clk);

        // Functional vectors
        run("t1 nominal",      12'h800, 5'h10, 13'h0150, 2'd2, 12'hD79);
        run("t3 incline clip", 12'h800, 5'h18, 13'h1EF0, 2'd3, 12'h000);
        run("t2 neg incline",  12'h800, 5'h10, 13'h1F22, 2'd3, 12'h158);
        run("t2 low torque",   12'h360, 5'h10, 13'h1F22, 2'd3, 12'h000);
        run("t4 flat",         12'h7E0, 5'h18, 13'h0000, 2'd3, 12'hB7C);
        run("t4 saturate",     12'h7E0, 5'h18, 13'h0080, 2'd3, 12'hFFF);

        // Inputs disturbed and start re-pulsed while busy
        set_in(12'h800, 5'h10, 13'h0150, 2'd2);
        start = 1'b1;
        tick();                                   // N: accept
        set_in(12'h7E0, 5'h18, 13'h0080, 2'd3);
        tick();                                   // N+1 (start high, ignored)
        check("immune busy@N+1", {11'd0, busy}, 12'd1);
        tick();                                   // N+2 (start high, ignored)
        start = 1'b0;
        check("immune valid@N+2", {11'd0, valid}, 12'd0);
        tick();                                   // N+3
        check("immune valid@N+3", {11'd0, valid}, 12'd1);
        check("immune target",    target_curr,    12'hD79);
        tick();                                   // N+4
        check("immune valid@N+4", {11'd0, valid}, 12'd0);
        check("immune busy@N+4",  {11'd0, busy},  12'd0);
        tick();
        check("immune valid@N+5", {11'd0, valid}, 12'd0);
        @(negedge clk);

        // start held high: re-accepted at N+4 with the inputs present then
        set_in(12'h7E0, 5'h18, 13'h0000, 2'd3);
        start = 1'b1;
        tick();                                   // N
        set_in(12'h800, 5'h10, 13'h0150, 2'd2);
        tick();                                   // N+1
        tick();                                   // N+2
        tick();                                   // N+3
        check("held valid@N+3",  {11'd0, valid}, 12'd1);
        check("held target1",    target_curr,    12'hB7C);
        tick();                                   // N+4: second accept
        start = 1'b0;
        check("held valid@N+4",  {11'd0, valid}, 12'd0);
        check("held busy@N+4",   {11'd0, busy},  12'd1);
        tick();                                   // N+5
        tick();                                   // N+6
        check("held valid@N+6",  {11'd0, valid}, 12'd0);
        tick();                                   // N+7
        check("held valid@N+7",  {11'd0, valid}, 12'd1);
        check("held target2",    target_curr,    12'hD79);
        @(negedge clk);

        // Asynchronous reset during MUL2
        set_in(12'h800, 5'h10, 13'h1F22, 2'd3);
        start = 1'b1;
        tick();                                   // N: accept
        start = 1'b0;
        tick();                                   // N+1: now in MUL2
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy",   {11'd0, busy},  12'd0);
        check("abort valid",  {11'd0, valid}, 12'd0);
        check("abort target", target_curr,    12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("abort no valid", {11'd0, valid}, 12'd0);
        end
        @(negedge clk);
        run("post reset", 12'h800, 5'h10, 13'h1F22, 2'd3, 12'h158);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/desired_drive_seq.md
# desired_drive_seq

Multi-cycle, resource-shared computation of the motor target current from averaged torque, cadence, incline and assist setting. A single shared multiplier is sequenced over three steps instead of a three-multiplier combinational chain. The block sits between the sensor-conditioning front end (torque averaging, cadence, inclinometer) and the PID/current loop. It holds its last result on `target_curr` between updates.

## Interface
- `TORQUE_MIN`, 12'h380: torque offset; torque at or below it gives zero assist.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a new computation; honoured only in IDLE.
- `avg_torque` in 12: unsigned averaged torque; latched on accept.
- `cadence_vec` in 5: unsigned cadence; latched on accept.
- `incline` in 13: signed incline; latched on accept.
- `setting` in 2: assist level 0–3; latched on accept.
- `busy` out 1: high while state is not IDLE.
- `valid` out 1: one-cycle pulse when `target_curr` is updated.
- `target_curr` out 12: registered unsigned target current; holds between updates.

## Operation
- Factor conditioning is combinational and applies to the inputs at accept:
  - `incline_sat`: saturate `incline` to 10-bit signed, range −512..511.
  - `incline_lim` (9-bit unsigned): compute `incline_sat` + 256, then clip to 0..511.
  - `cadence_factor` (6-bit): `cadence_vec` + 32 if `cadence_vec` > 1, else 0.
  - `torque_pos` (12-bit): `avg_torque` − `TORQUE_MIN` if `avg_torque` > `TORQUE_MIN`, else 0.
- The three factors plus `setting` are registered on accept.
- Shared multiplier: A operand 27 bits unsigned, B operand 9 bits unsigned, product truncated to 29 bits. It is the only multiply in the block.
- FSM states are IDLE, MUL1, MUL2 and MUL3:
  - IDLE: on `start`, latch the factors and go to MUL1.
  - MUL1: `p1` = `torque_pos` × `incline_lim` (21 bits used), then go to MUL2.
  - MUL2: `p2` = `p1` × `cadence_factor` (27 bits used), then go to MUL3.
  - MUL3: `p3` = `p2` × `setting` (29 bits). Write `target_curr` = 12'hFFF if any of `p3[28:26]` is set, else `p3[25:14]`. Pulse `valid`, then go to IDLE.
- `start` while busy is ignored and is not queued.
- Latched operands are immune to input changes after accept.

## Timing
- Reset values: state IDLE, `busy` 0, `valid` 0, `target_curr` 12'h000, all internal registers 0.
- Reset asserted mid-computation aborts immediately. No `valid` is produced and `target_curr` returns to 0.
- `start` is sampled high at edge N in IDLE:
  - Edge N: operands latched.
  - Edge N+1: `p1` registered.
  - Edge N+2: `p2` registered.
  - Edge N+3: `target_curr` updated and `valid` high for the following cycle.
- `busy` is high from after edge N until edge N+3. It is low in the cycle `valid` is high.
- `start` held high continuously is re-accepted at edge N+4. Minimum issue interval is 4 cycles.
- Fixed latency: no early exit on zero factors. Zero factors propagate to 0.

## Structure
- Package `desired_drive_pkg` holds:
  - the FSM state enum,
  - the `TORQUE_MIN` default,
  - the incline offset 256,
  - the cadence offset 32,
  - the result slice constants (saturate bits 28:26, result bits 25:14).
- Sub-module `drive_factors` is the combinational conditioning from (`avg_torque`, `cadence_vec`, `incline`) to (`torque_pos`, `cadence_factor`, `incline_lim`).
- The FSM, operand mux, shared multiplier and result register live in the top module.

## Test plan
- `avg_torque` 12'h800, `cadence_vec` 5'h10, `incline` 13'h0150, `setting` 2 → `valid` exactly 3 cycles after accept, `target_curr` 12'hD79.
- Same torque and cadence, `incline` 13'h1F22, `setting` 3 → 12'h158. In a separate run, `avg_torque` 12'h360 → 12'h000 (below `TORQUE_MIN`).
- `avg_torque` 12'h800, `cadence_vec` 5'h18, `incline` 13'h1EF0, `setting` 3 → 12'h000 (incline clipped to 0).
- `avg_torque` 12'h7E0, `cadence_vec` 5'h18, `setting` 3, `incline` 13'h0000 → 12'hB7C. Then `incline` 13'h0080 → 12'hFFF (saturation).
- Inputs changed and `start` re-pulsed during MUL1/MUL2 → result matches the originally latched inputs. Only one `valid` is produced. `start` held high gives results 4 cycles apart.
- `rst_n` pulsed low during MUL2 → `busy`, `valid` and `target_curr` read 0 asynchronously. No `valid` follows. The next `start` computes correctly.
